cookie_ctrl: RTL and testbench



---
 rtl/cookie_pkg.sv | 18 +
 rtl/cookie_ctrl_cnt.sv | 40 ++++
 rtl/cookie_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cookie_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cookie_pkg.sv
// cookie_pkg: shared types and constants for the cookie grid sequencer.
//   state_t  - sequencer states (IDLE, LOAD, RUN, CAPTURE, DUMP)
//   GRID_DIM - grid edge length; CELLS - cell count; CNT_W - cell counter width
package cookie_pkg;

  localparam int GRID_DIM = 16;
  localparam int CELLS    = GRID_DIM * GRID_DIM;
  localparam int CNT_W    = $clog2(CELLS) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    DUMP
  } state_t;

endpackage

// File: rtl/cookie_ctrl_cnt.sv
// cookie_ctrl_cnt: loadable up/down counter with terminal and zero flags.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   load/load_val - synchronous load (highest priority)
//   up, dn        - increment / decrement (up wins if both)
//   term          - compare value for at_term
//   at_term       - count == term
//   is_zero       - count == 0
module cookie_ctrl_cnt #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         up,
  input  logic         dn,
  input  logic [W-1:0] term,
  output logic         at_term,
  output logic         is_zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (up) begin
      count <= count + W'(1);
    end else if (dn) begin
      count <= count - W'(1);
    end
  end

  assign at_term = (count == term);
  assign is_zero = (count == '0);

endmodule

// File: rtl/cookie_ctrl.sv
// cookie_ctrl: sequencer for the 16x16 cookie cellular-automaton grid.
// Loads a serial seed, steps the grid gen_count generations, then captures
// the grid into the display chain and streams it out (cell 255 first).
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   cmd_load/cmd_run/cmd_dump      - commands, sampled in IDLE only
//   gen_count                      - generations, latched with cmd_run
//   in_bit/in_valid/in_ready       - seed stream (valid/ready)
//   out_bit/out_valid/out_ready    - dump stream (valid/ready)
//   busy, done                     - status; done pulses on first IDLE cycle
//   grid_en/grid_run/grid_display/grid_shift_in/grid_display_out - grid strobes
// Build option: define COOKIE_CTRL_RECIRC_EN to recirculate dumped bits back
// into the state chain so the grid survives a dump.
module cookie_ctrl #(
  parameter int CELLS = 256,
  parameter int GEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_load,
  input  logic             cmd_run,
  input  logic             cmd_dump,
  input  logic [GEN_W-1:0] gen_count,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             grid_en,
  output logic             grid_run,
  output logic             grid_display,
  output logic             grid_shift_in,
  input  logic             grid_display_out
);

  import cookie_pkg::*;

  // One counter serves both cell and generation counting, so size it for both.
  localparam int CW_CELL = $clog2(CELLS) + 1;
  localparam int CW      = (GEN_W + 1 > CW_CELL) ? GEN_W + 1 : CW_CELL;

  state_t        state, nxt;
  logic          done_q, done_nxt;
  logic          cnt_load, cnt_up, cnt_dn;
  logic [CW-1:0] cnt_val, cnt_term;
  logic          cnt_at_term, cnt_zero;
  logic          dump_feed;

`ifdef COOKIE_CTRL_RECIRC_EN
  assign dump_feed = grid_display_out;
`else
  assign dump_feed = 1'b0;
`endif

  // RUN ends on the decrement from 1; LOAD/DUMP end on the last cell.
  assign cnt_term = (state == RUN) ? CW'(1) : CW'(CELLS - 1);

  cookie_ctrl_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .up       (cnt_up),
    .dn       (cnt_dn),
    .term     (cnt_term),
    .at_term  (cnt_at_term),
    .is_zero  (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    nxt           = state;
    done_nxt      = 1'b0;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_bit       = 1'b0;
    grid_en       = 1'b0;
    grid_run      = 1'b0;
    grid_display  = 1'b0;
    grid_shift_in = 1'b0;
    cnt_load      = 1'b0;
    cnt_val       = '0;
    cnt_up        = 1'b0;
    cnt_dn        = 1'b0;
    unique case (state)
      IDLE: begin
        // Counter is preloaded every idle cycle so each operation starts clean.
        cnt_load = 1'b1;
        if (cmd_load) begin
          nxt = LOAD;
        end else if (cmd_run) begin
          nxt     = RUN;
          cnt_val = CW'(gen_count);
        end else if (cmd_dump) begin
          nxt = CAPTURE;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          grid_en       = 1'b1;
          grid_shift_in = in_bit;
          cnt_up        = 1'b1;
          if (cnt_at_term) begin
            nxt      = IDLE;
            done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt_zero) begin
          nxt      = IDLE;
          done_nxt = 1'b1;
        end else begin
          grid_en  = 1'b1;
          grid_run = 1'b1;
          cnt_dn   = 1'b1;
          if (cnt_at_term) begin
            nxt      = IDLE;
            done_nxt = 1'b1;
          end
        end
      end
      CAPTURE: begin
        grid_display = 1'b1;
        nxt          = DUMP;
      end
      DUMP: begin
        out_valid = 1'b1;
        out_bit   = grid_display_out;
        if (out_ready) begin
          grid_en       = 1'b1;
          grid_shift_in = dump_feed;
          cnt_up        = 1'b1;
          if (cnt_at_term) begin
            nxt      = IDLE;
            done_nxt = 1'b1;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_cookie_ctrl.sv
module tb_cookie_ctrl;

  localparam int N = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_load, cmd_run, cmd_dump;
  logic [7:0] gen_count;
  logic       in_bit, in_valid, in_ready;
  logic       out_bit, out_valid, out_ready;
  logic       busy, done;
  logic       grid_en, grid_run, grid_display, grid_shift_in, grid_display_out;

  always #5 clk = ~clk;

  cookie_ctrl #(.CELLS(N), .GEN_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_load         (cmd_load),
    .cmd_run          (cmd_run),
    .cmd_dump         (cmd_dump),
    .gen_count        (gen_count),
    .in_bit           (in_bit),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .out_bit          (out_bit),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .done             (done),
    .grid_en          (grid_en),
    .grid_run         (grid_run),
    .grid_display     (grid_display),
    .grid_shift_in    (grid_shift_in),
    .grid_display_out (grid_display_out)
  );

  // Stand-in grid: state chain shifts toward cell 255, display chain emits cell 255.
  // Its generation rule is "invert every cell", enough to tell runs apart.
  logic [N-1:0] st = '0;
  logic [N-1:0] dp = '0;
  assign grid_display_out = dp[N-1];
  always @(posedge clk) begin
    if (grid_display) begin
      dp <= st;
    end else if (grid_en && grid_run) begin
      st <= ~st;
    end else if (grid_en) begin
      st <= {st[N-2:0], grid_shift_in};
      dp <= {dp[N-2:0], 1'b0};
    end
  end

  int tests = 0;
  int failed = 0;
  int rdy_bad = 0;
  bit in_load = 0;

  logic s_busy, s_done, s_in_ready, s_out_valid, s_out_bit;
  logic s_en, s_run, s_disp, s_shift, s_acc_in, s_acc_out;

  logic [N-1:0] pat;   // accepted seed bits in acceptance order
  bit           inv;   // parity of generations run since the last load

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs sampled 1 unit later.
  task automatic tick();
    #1;
    s_busy = busy; s_done = done; s_in_ready = in_ready; s_out_valid = out_valid;
    s_out_bit = out_bit; s_en = grid_en; s_run = grid_run; s_disp = grid_display;
    s_shift = grid_shift_in;
    s_acc_in = in_valid & in_ready;
    s_acc_out = out_valid & out_ready;
    if (!in_load && in_ready) rdy_bad++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] outs_now();
    return {busy, done, in_ready, out_valid, out_bit, grid_en, grid_run, grid_display, grid_shift_in};
  endfunction

  task automatic do_load(input bit all_cmds, output int en_cnt, output int sh_bad,
                         output int acc, output int run_seen, output bit done_busy);
    cmd_load = 1; cmd_run = all_cmds; cmd_dump = all_cmds;
    tick();
    cmd_load = 0; cmd_run = 0; cmd_dump = 0;
    in_load = 1;
    en_cnt = 0; sh_bad = 0; acc = 0; run_seen = 0; done_busy = 1;
    for (int c = 0; c < 3000; c++) begin
      in_valid = (c % 2) == 1;
      in_bit = 1'($urandom);
      cmd_run = (c == 5);
      tick();
      if (s_en) en_cnt++;
      if (s_en && s_shift !== in_bit) sh_bad++;
      if (s_run) run_seen++;
      if (s_acc_in) begin
        if (acc < N) pat[acc] = in_bit;
        acc++;
      end
      if (s_done) begin
        done_busy = s_busy;
        break;
      end
    end
    in_valid = 0; cmd_run = 0;
    in_load = 0;
    inv = 0;
  endtask

  task automatic do_run(input logic [7:0] g, output int runs, output int k, output int last_run);
    cmd_run = 1; gen_count = g;
    tick();
    cmd_run = 0; gen_count = $urandom;
    runs = 0; k = 0; last_run = 0;
    for (int c = 1; c < 400; c++) begin
      tick();
      if (s_en && s_run) begin runs++; last_run = c; end
      if (s_done) begin k = c; break; end
    end
    inv = inv ^ g[0];
  endtask

  task automatic do_dump(input logic [N-1:0] exp_pat, output int mism, output int stall_bad,
                         output int disp_cnt, output int xfers, output bit cap_ok, output bit done_ok);
    bit   prev_stall;
    logic prev_bit;
    cmd_dump = 1;
    tick();
    cmd_dump = 0;
    out_ready = 0;
    tick();
    cap_ok = s_disp && !s_en && !s_out_valid;
    disp_cnt = s_disp ? 1 : 0;
    mism = 0; stall_bad = 0; xfers = 0; done_ok = 0;
    prev_stall = 0; prev_bit = 0;
    for (int c = 0; c < 6000; c++) begin
      out_ready = ($urandom_range(0, 99) < 30);
      tick();
      if (s_disp) disp_cnt++;
      if (prev_stall && s_out_valid && s_out_bit !== prev_bit) stall_bad++;
      prev_stall = s_out_valid && !s_acc_out;
      prev_bit = s_out_bit;
      if (s_acc_out) begin
        if (xfers < N && s_out_bit !== exp_pat[xfers]) mism++;
        xfers++;
      end
      if (s_done) begin
        done_ok = !s_busy && !s_out_valid;
        break;
      end
    end
    out_ready = 0;
  endtask

  int en_cnt, sh_bad, acc, run_seen, runs, k, last_run;
  int mism, stall_bad, disp_cnt, xfers;
  bit done_busy, cap_ok, done_ok;
  logic [N-1:0] first_exp;
  logic [7:0] g;

  initial begin
    rst_n = 0; cmd_load = 0; cmd_run = 0; cmd_dump = 0; gen_count = 0;
    in_bit = 0; in_valid = 0; out_ready = 0;
    pat = '0; inv = 0;
    #12;
    check("reset_outputs", 32'(outs_now()), 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    tick();
    check("idle_busy", 32'(s_busy), 32'd0);

    // Load with all three commands asserted together: LOAD must win.
    do_load(1'b1, en_cnt, sh_bad, acc, run_seen, done_busy);
    check("load_accepts", 32'(acc), 32'd256);
    check("load_grid_en_pulses", 32'(en_cnt), 32'd256);
    check("load_shift_in_bits", 32'(sh_bad), 32'd0);
    check("load_no_grid_run", 32'(run_seen), 32'd0);
    check("load_done_busy_low", 32'(done_busy), 32'd0);
    tick();
    check("done_single_pulse", 32'(s_done), 32'd0);

    do_run(8'd0, runs, k, last_run);
    check("run0_grid_runs", 32'(runs), 32'd0);
    check("run0_done_cycle", 32'(k), 32'd2);

    do_run(8'd5, runs, k, last_run);
    check("run5_grid_runs", 32'(runs), 32'd5);
    check("run5_consecutive", 32'(last_run), 32'd5);
    check("run5_done_cycle", 32'(k), 32'd6);

    g = 8'($urandom_range(1, 40));
    do_run(g, runs, k, last_run);
    check("runr_grid_runs", 32'(runs), 32'(g));
    check("runr_done_cycle", 32'(k), 32'(g) + 32'd1);

    first_exp = inv ? ~pat : pat;
    do_dump(first_exp, mism, stall_bad, disp_cnt, xfers, cap_ok, done_ok);
    check("dump1_capture_cycle", 32'(cap_ok), 32'd1);
    check("dump1_display_pulses", 32'(disp_cnt), 32'd1);
    check("dump1_transfers", 32'(xfers), 32'd256);
    check("dump1_pattern", 32'(mism), 32'd0);
    check("dump1_stall_stable", 32'(stall_bad), 32'd0);
    check("dump1_done", 32'(done_ok), 32'd1);

`ifdef COOKIE_CTRL_RECIRC_EN
    do_dump(first_exp, mism, stall_bad, disp_cnt, xfers, cap_ok, done_ok);
`else
    do_dump('0, mism, stall_bad, disp_cnt, xfers, cap_ok, done_ok);
`endif
    check("dump2_transfers", 32'(xfers), 32'd256);
    check("dump2_pattern", 32'(mism), 32'd0);

    // Reset in the middle of a load, at cell 100.
    cmd_load = 1;
    tick();
    cmd_load = 0;
    in_load = 1;
    acc = 0;
    for (int c = 0; c < 500 && acc < 100; c++) begin
      in_valid = 1; in_bit = 1'($urandom);
      tick();
      if (s_acc_in) acc++;
    end
    in_valid = 1;
    #2;
    rst_n = 0;
    #1;
    check("async_reset_outputs", 32'(outs_now()), 32'd0);
    in_load = 0;
    #2;
    rst_n = 1;
    @(posedge clk); #1;
    in_valid = 0;
    tick();
    check("reset_idle_after", 32'(s_busy), 32'd0);

    do_load(1'b0, en_cnt, sh_bad, acc, run_seen, done_busy);
    check("reload_full_accepts", 32'(acc), 32'd256);
    check("reload_grid_en_pulses", 32'(en_cnt), 32'd256);
    do_dump(pat, mism, stall_bad, disp_cnt, xfers, cap_ok, done_ok);
    check("dump3_pattern", 32'(mism), 32'd0);
    check("dump3_transfers", 32'(xfers), 32'd256);

    check("in_ready_outside_load", 32'(rdy_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
